// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demultiplexer with per-channel registered output stage; packets are kept whole.
// Optional DEMUX1TO2_BEAT_CNT_EN adds 16-bit per-channel output handshake counters cnt0/cnt1.
module demux1to2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_data,
  input  logic             A_valid,
  input  logic             A_last,
  output logic             A_ready,
  input  logic             S,
  output logic [WIDTH-1:0] Y0_data,
  output logic             Y0_valid,
  output logic             Y0_last,
  input  logic             Y0_ready,
  output logic [WIDTH-1:0] Y1_data,
  output logic             Y1_valid,
  output logic             Y1_last,
  input  logic             Y1_ready
`ifdef DEMUX1TO2_BEAT_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t state;
  logic   sel_lock;
  logic   sel_eff;
  logic   acc;

  // Select is live only between packets; mid-packet the captured select steers every beat.
  assign sel_eff = (state == LOCK) ? sel_lock : S;
  assign A_ready = sel_eff ? (~Y1_valid | Y1_ready) : (~Y0_valid | Y0_ready);
  assign acc     = A_valid & A_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_lock <= 1'b0;
    end else if (acc) begin
      if (state == IDLE && !A_last) begin
        state    <= LOCK;
        sel_lock <= S;
      end else if (state == LOCK && A_last) begin
        state <= IDLE;
      end
    end
  end

  // Output stage: a new beat may load in the same cycle the held one drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y0_valid <= 1'b0;
      Y0_data  <= '0;
      Y0_last  <= 1'b0;
      Y1_valid <= 1'b0;
      Y1_data  <= '0;
      Y1_last  <= 1'b0;
    end else begin
      if (acc && !sel_eff) begin
        Y0_data  <= A_data;
        Y0_last  <= A_last;
        Y0_valid <= 1'b1;
      end else if (Y0_ready) begin
        Y0_valid <= 1'b0;
      end
      if (acc && sel_eff) begin
        Y1_data  <= A_data;
        Y1_last  <= A_last;
        Y1_valid <= 1'b1;
      end else if (Y1_ready) begin
        Y1_valid <= 1'b0;
      end
    end
  end

`ifdef DEMUX1TO2_BEAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (Y0_valid && Y0_ready) cnt0 <= cnt0 + 16'd1;
      if (Y1_valid && Y1_ready) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream: routing, packet lock, backpressure, independence, reset.
module tb_demux1to2_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A_data;
  logic       A_valid, A_last, A_ready, S;
  logic [7:0] Y0_data, Y1_data;
  logic       Y0_valid, Y0_last, Y0_ready;
  logic       Y1_valid, Y1_last, Y1_ready;
`ifdef DEMUX1TO2_BEAT_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  demux1to2_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .A_data(A_data), .A_valid(A_valid), .A_last(A_last), .A_ready(A_ready),
    .S(S),
    .Y0_data(Y0_data), .Y0_valid(Y0_valid), .Y0_last(Y0_last), .Y0_ready(Y0_ready),
    .Y1_data(Y1_data), .Y1_valid(Y1_valid), .Y1_last(Y1_last), .Y1_ready(Y1_ready)
`ifdef DEMUX1TO2_BEAT_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; A_data = '0; A_valid = 1'b0; A_last = 1'b0; S = 1'b0;
    Y0_ready = 1'b0; Y1_ready = 1'b0;
    tick(); tick();
    chk("rst_y0_valid", Y0_valid, 0);
    chk("rst_y1_valid", Y1_valid, 0);
    chk("rst_y0_data", Y0_data, 0);
    chk("rst_y1_data", Y1_data, 0);
    chk("rst_y0_last", Y0_last, 0);
    chk("rst_y1_last", Y1_last, 0);
    rst = 1'b0;

    // Single beat to Y0
    S = 1'b0; A_valid = 1'b1; A_last = 1'b1; A_data = 8'h5A; Y0_ready = 1'b1;
    #1 chk("single_a_ready", A_ready, 1);
    tick();
    A_valid = 1'b0;
    chk("single_y0_valid", Y0_valid, 1);
    chk("single_y0_data", Y0_data, 8'h5A);
    chk("single_y0_last", Y0_last, 1);
    chk("single_y1_valid", Y1_valid, 0);
    tick();
    chk("single_drained", Y0_valid, 0);

    // Packet lock: S toggles after beat 0, all beats stay on Y1
    Y1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      S = (i % 2 == 0) ? 1'b1 : 1'b0;
      A_valid = 1'b1; A_data = 8'h10 + 8'(i); A_last = (i == 3);
      tick();
      chk("lock_y1_valid", Y1_valid, 1);
      chk("lock_y1_data", Y1_data, 32'h10 + i);
      chk("lock_y1_last", Y1_last, (i == 3) ? 1 : 0);
      chk("lock_y0_valid", Y0_valid, 0);
    end
    A_valid = 1'b0;
    tick();
    chk("lock_y1_drained", Y1_valid, 0);

    // Backpressure on Y0
    Y0_ready = 1'b0; S = 1'b0; A_valid = 1'b1; A_data = 8'h21; A_last = 1'b1;
    tick();
    A_data = 8'h22;
    #1 chk("bp_a_ready_low", A_ready, 0);
    tick();
    chk("bp_y0_valid", Y0_valid, 1);
    chk("bp_y0_data_stable", Y0_data, 8'h21);
    Y0_ready = 1'b1;
    #1 chk("bp_a_ready_high", A_ready, 1);
    tick();
    A_valid = 1'b0;
    chk("bp_y0_next_data", Y0_data, 8'h22);
    chk("bp_y0_next_valid", Y0_valid, 1);
    tick();
    chk("bp_y0_drained", Y0_valid, 0);

    // Independence: Y1 stalled, new packet flows to Y0
    Y1_ready = 1'b0; S = 1'b1; A_valid = 1'b1; A_data = 8'h31; A_last = 1'b1;
    tick();
    S = 1'b0; A_data = 8'h41; A_last = 1'b0;
    #1 chk("ind_a_ready", A_ready, 1);
    tick();
    chk("ind_y0_data0", Y0_data, 8'h41);
    chk("ind_y1_held", Y1_data, 8'h31);
    chk("ind_y1_valid", Y1_valid, 1);
    S = 1'b1; A_data = 8'h42; A_last = 1'b1;
    tick();
    chk("ind_y0_data1", Y0_data, 8'h42);
    chk("ind_y0_last1", Y0_last, 1);
    chk("ind_y1_still", Y1_data, 8'h31);
    A_valid = 1'b0; Y1_ready = 1'b1;
    tick();
    chk("ind_y1_drained", Y1_valid, 0);
    chk("ind_y0_drained", Y0_valid, 0);

    // Reset mid-packet on Y1
    S = 1'b1; A_valid = 1'b1; A_last = 1'b0; A_data = 8'h51;
    tick();
    S = 1'b0; A_data = 8'h52;
    tick();
    chk("mid_y1_beat2", Y1_data, 8'h52);
    rst = 1'b1; A_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_y0_valid", Y0_valid, 0);
    chk("mid_rst_y1_valid", Y1_valid, 0);
    S = 1'b0; A_valid = 1'b1; A_data = 8'h61; A_last = 1'b1;
    tick();
    A_valid = 1'b0;
    chk("mid_new_y0_valid", Y0_valid, 1);
    chk("mid_new_y0_data", Y0_data, 8'h61);
    chk("mid_new_y1_valid", Y1_valid, 0);
    tick();

`ifdef DEMUX1TO2_BEAT_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt0_reset", cnt0, 0);
    chk("cnt1_reset", cnt1, 0);
    Y0_ready = 1'b1; Y1_ready = 1'b1; A_last = 1'b1; A_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      S = (i >= 3); A_data = 8'(i);
      tick();
    end
    A_valid = 1'b0;
    tick();
    chk("cnt0_three", cnt0, 3);
    chk("cnt1_two", cnt1, 2);
    S = 1'b0; A_valid = 1'b1;
    for (int i = 0; i < 65532; i++) tick();
    A_valid = 1'b0;
    tick();
    chk("cnt0_max", cnt0, 16'hFFFF);
    A_valid = 1'b1;
    tick();
    A_valid = 1'b0;
    tick();
    chk("cnt0_wrap", cnt0, 0);
    chk("cnt1_unchanged", cnt1, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
